fp32_div_seq: RTL
=================

Name: fp32_div_seq

Overview:
Sequential IEEE-754 single-precision divider (c = a / b), the inverse operation of the existing combinational floatMul datapath. It uses a radix-2 restoring mantissa divider with a valid/ready handshake on both sides, and sits beside the multiplier in the npc_cnn arithmetic top. It uses flush-to-zero semantics and round-to-nearest-even.

Parameters:
WIDTH, 32, operand/result width; only 32 supported.
EXP_W, 8, exponent field width.
MAN_W, 23, stored fraction width.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  32  dividend (fp32).
b  input  32  divisor (fp32).
out_valid  output  1  result valid; held until consumed.
out_ready  input  1  consumer accepts result.
c  output  32  quotient (fp32).
flags  output  4  {invalid, div_by_zero, overflow, underflow}; valid with out_valid.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE, out_valid=0, c=0, flags=0, in_ready=1 next cycle. Reset mid-operation discards the in-flight op; no partial result appears.
- States: IDLE -> (accept) DIV or DONE; DIV (26 iterations) -> ROUND -> DONE; DONE -> (out_valid & out_ready) IDLE.
- Accept: in_valid & in_ready at an edge latches a and b, and latches sign = a[31]^b[31].
- Special cases are resolved at accept and go straight to DONE, so out_valid is high on the following cycle (latency 1).
- Subnormal inputs are treated as signed zero.
- Special-case table:
  - Any NaN input, 0/0, or inf/inf: c=0x7FC00000, invalid=1.
  - finite/0 (nonzero dividend): signed inf, div_by_zero=1.
  - inf/finite: signed inf, no flag.
  - 0/x, finite/inf: signed zero, no flag.
- Normal path:
  - ma={1,fa}, mb={1,fb}, each 24 bits.
  - Exponent register is 10-bit signed: e = ea - eb + 127.
  - DIV: one quotient bit per cycle for 26 cycles. Partial remainder is 25 bits; if rem >= mb, subtract and set bit 1; then rem <<= 1.
  - ROUND (1 cycle):
    - If q[25]==0, shift q left by 1 and e -= 1.
    - Mantissa = q[25:2], guard = q[1], sticky = q[0] | (rem != 0).
    - Round to nearest even: increment when guard & (sticky | lsb).
    - Mantissa carry-out: mantissa = 1.0, e += 1.
    - e >= 255: signed inf, overflow=1.
    - e <= 0: signed zero, underflow=1 (FTZ).
  - Normal-path latency: out_valid asserts exactly 28 cycles after the accept edge.
- Output hold: while out_valid=1 and out_ready=0, c and flags are stable, in_ready=0, and in_valid is ignored.
- Consume: at the edge where out_valid & out_ready, the block returns to IDLE and out_valid drops. in_ready rises in that cycle; there is no same-cycle accept-while-outputting.
- Inputs a and b are don't-care when not being accepted.

Decomposition:
- Shared package fp32_pkg holds:
  - constants FP32_BIAS=127, FP32_QNAN=32'h7FC00000, FP32_INF=32'h7F800000;
  - flag bit indices FLG_INV=3, FLG_DZ=2, FLG_OF=1, FLG_UF=0;
  - the div state encoding (IDLE, DIV, ROUND, DONE).
- One sub-module, fp32_unpack (combinational): splits an operand into sign, exponent and significand and classifies it as is_zero, is_inf or is_nan. Subnormals classify as zero. It is reusable by floatMul later.

Test Plan:
1. a=0x40C00000 (6.0), b=0x40000000 (2.0) -> c=0x40400000, flags=0, out_valid exactly 28 cycles after accept. Then a=0xC0C00000 -> c=0xC0400000.
2. a=0x3F800000 (1.0), b=0x40400000 (3.0) -> c=0x3EAAAAAB (RNE round-up), flags=0.
3. Specials, each with out_valid 1 cycle after accept:
   - 1.0/0.0 -> c=0x7F800000, flags=4'b0100.
   - 0/0 -> c=0x7FC00000, flags=4'b1000.
   - 0x7FC00001/1.0 -> c=0x7FC00000, flags=4'b1000.
4. Range limits:
   - a=0x7F000000, b=0x3E800000 -> c=0x7F800000, flags=4'b0010.
   - a=0x00800000, b=0x40000000 -> c=0x00000000, flags=4'b0001.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid while driving in_valid=1 with new operands -> c and flags unchanged, in_ready=0, no accept. Raise out_ready -> out_valid=0 and in_ready=1 on the next cycle, and the pending operands are accepted then.
6. Assert rst for 1 cycle at DIV iteration 10 -> out_valid=0, in_ready=1 after reset. The next op (6.0/2.0) yields 0x40400000 with 28-cycle latency.

Source files
------------

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pkg
// Description : Shared fp32 constants, flag bit positions and divider states.
// Revision    : 1.0 - initial release
// ============================================================================
package fp32_pkg;

    localparam int          FP32_BIAS = 127;
    localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_INF  = 32'h7F80_0000;

    // Flag vector layout: {invalid, div_by_zero, overflow, underflow}
    localparam int FLG_INV = 3;
    localparam int FLG_DZ  = 2;
    localparam int FLG_OF  = 1;
    localparam int FLG_UF  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/fp32_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp32_unpack
// Description : Splits an fp32 operand into fields and classifies it
//               (subnormals flush to zero).
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_unpack
    import fp32_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] i_op,
    output logic                 o_sign,
    output logic [EXP_W-1:0]     o_exp,
    output logic [MAN_W:0]       o_sig,
    output logic                 o_is_zero,
    output logic                 o_is_inf,
    output logic                 o_is_nan
);

    always_comb begin
        o_sign    = i_op[EXP_W+MAN_W];
        o_exp     = i_op[EXP_W+MAN_W-1:MAN_W];
        o_is_zero = (o_exp == '0);
        o_is_inf  = (o_exp == '1) && (i_op[MAN_W-1:0] == '0);
        o_is_nan  = (o_exp == '1) && (i_op[MAN_W-1:0] != '0);
        o_sig     = o_is_zero ? '0 : {1'b1, i_op[MAN_W-1:0]};
    end

endmodule
`default_nettype wire

// File: rtl/fp32_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp32_div_seq
// Description : Sequential fp32 divider, radix-2 restoring, FTZ, RNE, with
//               valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_div_seq
    import fp32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [3:0]       flags
);

    localparam int               c_SIG_W     = MAN_W + 1;
    localparam int               c_REM_W     = MAN_W + 2;
    localparam int               c_Q_W       = MAN_W + 3;
    localparam int               c_E_W       = EXP_W + 2;
    localparam logic [4:0]       c_LAST_ITER = 5'(MAN_W + 2);
    localparam logic [c_E_W-1:0] c_EXP_MAX   = c_E_W'((1 << EXP_W) - 1);

    div_state_e         r_state_q, w_state_d;
    logic               r_sign_q,  w_sign_d;
    logic [c_E_W-1:0]   r_exp_q,   w_exp_d;
    logic [c_SIG_W-1:0] r_mb_q,    w_mb_d;
    logic [c_REM_W-1:0] r_rem_q,   w_rem_d;
    logic [c_Q_W-1:0]   r_quo_q,   w_quo_d;
    logic [4:0]         r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_c_q,     w_c_d;
    logic [3:0]         r_flags_q, w_flags_d;

    logic               w_sign_a, w_sign_b, w_zero_a, w_zero_b;
    logic               w_inf_a, w_inf_b, w_nan_a, w_nan_b;
    logic [EXP_W-1:0]   w_exp_a, w_exp_b;
    logic [c_SIG_W-1:0] w_sig_a, w_sig_b;

    fp32_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
        .i_op(a), .o_sign(w_sign_a), .o_exp(w_exp_a), .o_sig(w_sig_a),
        .o_is_zero(w_zero_a), .o_is_inf(w_inf_a), .o_is_nan(w_nan_a)
    );

    fp32_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
        .i_op(b), .o_sign(w_sign_b), .o_exp(w_exp_b), .o_sig(w_sig_b),
        .o_is_zero(w_zero_b), .o_is_inf(w_inf_b), .o_is_nan(w_nan_b)
    );

    logic               w_sign_in, w_spec;
    logic [WIDTH-1:0]   w_spec_c;
    logic [3:0]         w_spec_flags;
    logic [c_E_W-1:0]   w_exp_init;

    // Operand classification; anything not listed here goes down the divider.
    always_comb begin
        w_sign_in    = w_sign_a ^ w_sign_b;
        w_exp_init   = c_E_W'(w_exp_a) - c_E_W'(w_exp_b) + c_E_W'(FP32_BIAS);
        w_spec       = 1'b1;
        w_spec_c     = '0;
        w_spec_flags = '0;
        if (w_nan_a || w_nan_b || (w_zero_a && w_zero_b) || (w_inf_a && w_inf_b)) begin
            w_spec_c              = FP32_QNAN;
            w_spec_flags[FLG_INV] = 1'b1;
        end else if (w_inf_a) begin
            w_spec_c = {w_sign_in, FP32_INF[WIDTH-2:0]};
        end else if (w_zero_b) begin
            w_spec_c             = {w_sign_in, FP32_INF[WIDTH-2:0]};
            w_spec_flags[FLG_DZ] = 1'b1;
        end else if (w_zero_a || w_inf_b) begin
            w_spec_c = {w_sign_in, {(WIDTH-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic               w_rem_ge;
    logic [c_REM_W-1:0] w_rem_sub;
    logic [c_REM_W-1:0] w_qn;
    logic [c_E_W-1:0]   w_en, w_er;
    logic               w_guard, w_sticky, w_inc;
    logic [MAN_W:0]     w_frac_r;
    logic [WIDTH-1:0]   w_round_c;
    logic [3:0]         w_round_flags;

    always_comb begin
        w_rem_ge  = (r_rem_q >= {1'b0, r_mb_q});
        w_rem_sub = r_rem_q - (w_rem_ge ? {1'b0, r_mb_q} : '0);

        // w_qn drops the hidden bit: after normalisation it is always one.
        w_qn     = r_quo_q[c_Q_W-1] ? r_quo_q[c_Q_W-2:0] : {r_quo_q[c_Q_W-3:0], 1'b0};
        w_en     = r_quo_q[c_Q_W-1] ? r_exp_q : r_exp_q - c_E_W'(1);
        w_guard  = w_qn[1];
        w_sticky = w_qn[0] | (|r_rem_q);
        w_inc    = w_guard & (w_sticky | w_qn[2]);
        w_frac_r = {1'b0, w_qn[c_REM_W-1:2]} + {{MAN_W{1'b0}}, w_inc};
        w_er     = w_frac_r[MAN_W] ? w_en + c_E_W'(1) : w_en;

        w_round_flags = '0;
        w_round_c     = {r_sign_q, w_er[EXP_W-1:0], w_frac_r[MAN_W-1:0]};
        if (!w_er[c_E_W-1] && (w_er >= c_EXP_MAX)) begin
            w_round_c             = {r_sign_q, FP32_INF[WIDTH-2:0]};
            w_round_flags[FLG_OF] = 1'b1;
        end else if (w_er[c_E_W-1] || (w_er == '0)) begin
            w_round_c             = {r_sign_q, {(WIDTH-1){1'b0}}};
            w_round_flags[FLG_UF] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state_q <= ST_IDLE;
        else     r_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:  if (in_valid) w_state_d = w_spec ? ST_DONE : ST_DIV;
            ST_DIV:   if (r_cnt_q == c_LAST_ITER) w_state_d = ST_ROUND;
            ST_ROUND: w_state_d = ST_DONE;
            ST_DONE:  if (out_ready) w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state_q == ST_IDLE);
        out_valid = (r_state_q == ST_DONE);
        c         = r_c_q;
        flags     = r_flags_q;
    end

    always_comb begin
        w_sign_d  = r_sign_q;
        w_exp_d   = r_exp_q;
        w_mb_d    = r_mb_q;
        w_rem_d   = r_rem_q;
        w_quo_d   = r_quo_q;
        w_cnt_d   = r_cnt_q;
        w_c_d     = r_c_q;
        w_flags_d = r_flags_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    w_sign_d  = w_sign_in;
                    w_exp_d   = w_exp_init;
                    w_mb_d    = w_sig_b;
                    w_rem_d   = {1'b0, w_sig_a};
                    w_quo_d   = '0;
                    w_cnt_d   = '0;
                    w_c_d     = w_spec_c;
                    w_flags_d = w_spec_flags;
                end
            end
            ST_DIV: begin
                w_cnt_d = r_cnt_q + 5'd1;
                w_rem_d = w_rem_sub << 1;
                w_quo_d = {r_quo_q[c_Q_W-2:0], w_rem_ge};
            end
            ST_ROUND: begin
                w_c_d     = w_round_c;
                w_flags_d = w_round_flags;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_q  <= 1'b0;
            r_exp_q   <= '0;
            r_mb_q    <= '0;
            r_rem_q   <= '0;
            r_quo_q   <= '0;
            r_cnt_q   <= '0;
            r_c_q     <= '0;
            r_flags_q <= '0;
        end else begin
            r_sign_q  <= w_sign_d;
            r_exp_q   <= w_exp_d;
            r_mb_q    <= w_mb_d;
            r_rem_q   <= w_rem_d;
            r_quo_q   <= w_quo_d;
            r_cnt_q   <= w_cnt_d;
            r_c_q     <= w_c_d;
            r_flags_q <= w_flags_d;
        end
    end

endmodule
`default_nettype wire
